// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the FPGA configuration loader.
// The parity-check states are only used when FPGA_CFG_PARITY_EN is defined.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

    localparam int DEFAULT_CHAIN_LEN = 64;

    // Wide enough to hold the value CHAIN_LEN itself, not just CHAIN_LEN-1.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/fpga_cfg_sync.sv
// N-stage flip-flop synchroniser for one asynchronous pin input.
module fpga_cfg_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/fpga_cfg_loader.sv
// Serial bitstream loader feeding the fabric configuration chain; gates fabric enable.
// Define FPGA_CFG_PARITY_EN to add a trailing even-parity bit with CHECK/ERROR states.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN   = DEFAULT_CHAIN_LEN,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_start_i,
    input  logic cfg_strb_i,
    input  logic cfg_data_i,
    output logic cfg_bit_o,
    output logic cfg_shift_o,
    output logic cfg_busy_o,
    output logic fabric_en_o,
    output logic cfg_err_o
);

    localparam int            CW       = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LEN);

    logic start_s;
    logic strb_s;
    logic data_s;

    fpga_cfg_sync #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk (clk),
        .rst (rst),
        .d   (cfg_start_i),
        .q   (start_s)
    );

    fpga_cfg_sync #(.STAGES(SYNC_STAGES)) u_sync_strb (
        .clk (clk),
        .rst (rst),
        .d   (cfg_strb_i),
        .q   (strb_s)
    );

    fpga_cfg_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (cfg_data_i),
        .q   (data_s)
    );

    logic start_d;
    logic strb_d;
    logic start_rise;
    logic strb_rise;
    logic data_d;

    // Registered edge pulses; data is delayed by the same stage so it lines up with strb_rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_d    <= 1'b0;
            strb_d     <= 1'b0;
            start_rise <= 1'b0;
            strb_rise  <= 1'b0;
            data_d     <= 1'b0;
        end else begin
            start_d    <= start_s;
            strb_d     <= strb_s;
            start_rise <= start_s & ~start_d;
            strb_rise  <= strb_s & ~strb_d;
            data_d     <= data_s;
        end
    end

    cfg_state_t    state;
    logic [CW-1:0] cnt;
`ifdef FPGA_CFG_PARITY_EN
    logic          parity;
    logic          err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cfg_bit_o   <= 1'b0;
            cfg_shift_o <= 1'b0;
            cfg_busy_o  <= 1'b0;
            fabric_en_o <= 1'b0;
`ifdef FPGA_CFG_PARITY_EN
            parity      <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            cfg_shift_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_rise) begin
                        state       <= ST_LOAD;
                        cnt         <= '0;
                        cfg_busy_o  <= 1'b1;
                        fabric_en_o <= 1'b0;
`ifdef FPGA_CFG_PARITY_EN
                        parity      <= 1'b0;
                        err_q       <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    // Exit is decided while the final shift pulse is on the chain.
                    if (start_rise) begin
                        cnt <= '0;
`ifdef FPGA_CFG_PARITY_EN
                        parity <= 1'b0;
`endif
                    end else if (cnt == LAST_CNT) begin
`ifdef FPGA_CFG_PARITY_EN
                        state <= ST_CHECK;
`else
                        state       <= ST_DONE;
                        cfg_busy_o  <= 1'b0;
                        fabric_en_o <= 1'b1;
`endif
                    end else if (strb_rise) begin
                        cfg_bit_o   <= data_d;
                        cfg_shift_o <= 1'b1;
                        cnt         <= cnt + 1'b1;
`ifdef FPGA_CFG_PARITY_EN
                        parity      <= parity ^ data_d;
`endif
                    end
                end
`ifdef FPGA_CFG_PARITY_EN
                ST_CHECK: begin
                    if (start_rise) begin
                        state  <= ST_LOAD;
                        cnt    <= '0;
                        parity <= 1'b0;
                    end else if (strb_rise) begin
                        cfg_busy_o <= 1'b0;
                        if (data_d == parity) begin
                            state       <= ST_DONE;
                            fabric_en_o <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FPGA_CFG_PARITY_EN
    assign cfg_err_o = err_q;
`else
    assign cfg_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader with CHAIN_LEN=8, SYNC_STAGES=2.
// Parity scenarios are included when FPGA_CFG_PARITY_EN is defined.
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    localparam int CHAIN_LEN   = 8;
    localparam int SYNC_STAGES = 2;
    // Strobe driven after cycle C: sync (2) + edge register (1) + output register (1).
    localparam int LATENCY     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_start_i = 1'b0;
    logic cfg_strb_i = 1'b0;
    logic cfg_data_i = 1'b0;
    logic cfg_bit_o;
    logic cfg_shift_o;
    logic cfg_busy_o;
    logic fabric_en_o;
    logic cfg_err_o;

    typedef struct packed {
        logic b;
        int   due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc_cnt = 0;
    int   pulse_cnt = 0;
    int   last_shift_cyc = -1;
    int   fe_rise_cyc = -1;
    int   p0;
    logic prev_shift = 1'b0;
    logic prev_fe = 1'b0;
    logic [7:0] vec_a = 8'b1011_0010;
    logic [7:0] vec_b = 8'b0110_1100;
    logic [7:0] vec_c = 8'b1100_1010;

    fpga_cfg_loader #(
        .CHAIN_LEN   (CHAIN_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start_i (cfg_start_i),
        .cfg_strb_i  (cfg_strb_i),
        .cfg_data_i  (cfg_data_i),
        .cfg_bit_o   (cfg_bit_o),
        .cfg_shift_o (cfg_shift_o),
        .cfg_busy_o  (cfg_busy_o),
        .fabric_en_o (fabric_en_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: every shift pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cfg_shift_o) begin
            pulse_cnt++;
            last_shift_cyc = cyc_cnt;
            checkOutput("shift single-cycle", int'(prev_shift), 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected shift", int'(cfg_shift_o), 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("shift bit", int'(cfg_bit_o), int'(mon_e.b));
                checkOutput("shift latency", cyc_cnt, mon_e.due);
            end
        end
        if (fabric_en_o && !prev_fe) fe_rise_cyc = cyc_cnt;
        prev_shift = cfg_shift_o;
        prev_fe    = fabric_en_o;
    end

    task automatic applyStimulus(input logic d, input logic expect_shift);
        @(negedge clk);
        cfg_data_i = d;
        repeat (3) @(negedge clk);
        cfg_strb_i = 1'b1;
        if (expect_shift) exp_q.push_back('{b: d, due: cyc_cnt + LATENCY});
        repeat (4) @(negedge clk);
        cfg_strb_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendBits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) applyStimulus(v[i], 1'b1);
    endtask

    task automatic startPulse();
        @(negedge clk);
        cfg_start_i = 1'b1;
        repeat (5) @(negedge clk);
        cfg_start_i = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic finishLoad(input logic p);
`ifdef FPGA_CFG_PARITY_EN
        checkOutput("check state", int'(dut.state), int'(ST_CHECK));
        checkOutput("busy in check", int'(cfg_busy_o), 1);
        checkOutput("fabric off in check", int'(fabric_en_o), 0);
        applyStimulus(p, 1'b0);
`else
        if (p) $display("[TB] note: parity bit ignored in this build");
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset shift", int'(cfg_shift_o), 0);
        checkOutput("reset bit", int'(cfg_bit_o), 0);
        checkOutput("reset busy", int'(cfg_busy_o), 0);
        checkOutput("reset fabric", int'(fabric_en_o), 0);
        checkOutput("reset err", int'(cfg_err_o), 0);
        checkOutput("reset state", int'(dut.state), int'(ST_IDLE));
        checkOutput("reset cnt", int'(dut.cnt), 0);
        rst = 1'b0;

        // Strobes without start are ignored
        for (int i = 0; i < 3; i++) applyStimulus(i[0], 1'b0);
        checkOutput("idle fabric", int'(fabric_en_o), 0);
        checkOutput("idle busy", int'(cfg_busy_o), 0);

        // Full load of 8'b1011_0010
        startPulse();
        checkOutput("load busy", int'(cfg_busy_o), 1);
        sendBits(vec_a, 8);
        finishLoad(1'b0);
`ifndef FPGA_CFG_PARITY_EN
        checkOutput("fabric rise cycle", fe_rise_cyc, last_shift_cyc + 1);
`endif
        checkOutput("done fabric", int'(fabric_en_o), 1);
        checkOutput("done busy", int'(cfg_busy_o), 0);
        checkOutput("done err", int'(cfg_err_o), 0);
        checkOutput("done state", int'(dut.state), int'(ST_DONE));

        // Restart mid-load: 5 bits, start, 8 bits -> 13 pulses
        p0 = pulse_cnt;
        startPulse();
        checkOutput("restart fabric drop", int'(fabric_en_o), 0);
        sendBits(vec_b, 5);
        startPulse();
        checkOutput("restart cnt", int'(dut.cnt), 0);
        checkOutput("restart fabric", int'(fabric_en_o), 0);
        sendBits(vec_c, 8);
        finishLoad(1'b0);
        checkOutput("restart pulses", pulse_cnt - p0, 13);
        checkOutput("restart done", int'(fabric_en_o), 1);

        // Reset mid-load after 4 bits
        startPulse();
        sendBits(vec_a, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst shift", int'(cfg_shift_o), 0);
        checkOutput("midrst bit", int'(cfg_bit_o), 0);
        checkOutput("midrst busy", int'(cfg_busy_o), 0);
        checkOutput("midrst fabric", int'(fabric_en_o), 0);
        checkOutput("midrst state", int'(dut.state), int'(ST_IDLE));
        checkOutput("midrst cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("post-rst fabric", int'(fabric_en_o), 0);
        checkOutput("post-rst busy", int'(cfg_busy_o), 0);

`ifdef FPGA_CFG_PARITY_EN
        // Wrong parity bit -> ERROR
        startPulse();
        sendBits(vec_a, 8);
        finishLoad(1'b1);
        checkOutput("parity err", int'(cfg_err_o), 1);
        checkOutput("parity err fabric", int'(fabric_en_o), 0);
        checkOutput("parity err busy", int'(cfg_busy_o), 0);
        checkOutput("parity err state", int'(dut.state), int'(ST_ERROR));
        startPulse();
        checkOutput("err cleared", int'(cfg_err_o), 0);
        checkOutput("err reload busy", int'(cfg_busy_o), 1);
`else
        startPulse();
`endif

        // Start coincident with a strobe during LOAD: bit dropped, counter 0
        sendBits(vec_a, 2);
        @(negedge clk);
        cfg_data_i = 1'b1;
        repeat (3) @(negedge clk);
        cfg_start_i = 1'b1;
        cfg_strb_i  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("coincide cnt", int'(dut.cnt), 0);
        checkOutput("coincide busy", int'(cfg_busy_o), 1);
        checkOutput("coincide state", int'(dut.state), int'(ST_LOAD));
        cfg_start_i = 1'b0;
        cfg_strb_i  = 1'b0;
        repeat (5) @(negedge clk);
        sendBits(vec_a, 7);
        checkOutput("coincide 7 bits fabric", int'(fabric_en_o), 0);
        applyStimulus(vec_a[0], 1'b1);
        finishLoad(1'b0);
        checkOutput("coincide done", int'(fabric_en_o), 1);

        repeat (4) @(negedge clk);
        checkOutput("queue drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
